// File: rtl/cap_touch_scanner.sv
// N-channel capacitive touch scanner: shared charge drive, parallel discharge timing, per-channel debounce and sticky hit flags.
// Optional CAP_BASELINE_EN adds a per-channel 1/16 IIR baseline so the threshold becomes relative to the idle count.
module cap_touch_lane #(
    parameter int CNT_W    = 12,
    parameter int DEBOUNCE = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             sens_i,
    input  logic             charge_i,
    input  logic             measure_i,
    input  logic             eval_i,
    input  logic [CNT_W-1:0] threshold_i,
    input  logic             hit_clr_i,
    output logic             active_o,
    output logic [CNT_W-1:0] count_o,
    output logic             touch_o,
    output logic             hit_o
);
    localparam int DBW = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       sync_q;
    logic             alive_q;
    logic [CNT_W-1:0] cnt_q, last_q, thr_eff;
    logic [DBW-1:0]   db_q, db_d;
    logic             touch_q, touch_d, hit_q, raw, rise;

    assign active_o = alive_q & sync_q[1];
    assign raw      = (cnt_q >= thr_eff);
    assign count_o  = last_q;
    assign touch_o  = touch_q;
    assign hit_o    = hit_q;

    always_comb begin
        db_d    = db_q;
        touch_d = touch_q;
        rise    = 1'b0;
        if (eval_i) begin
            if (raw == touch_q) begin
                db_d = '0;
            end else if (db_q == DBW'(DEBOUNCE - 1)) begin
                db_d    = '0;
                touch_d = ~touch_q;
                rise    = ~touch_q;
            end else begin
                db_d = db_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            alive_q <= 1'b0;
            cnt_q   <= '0;
            last_q  <= '0;
            db_q    <= '0;
            touch_q <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], sens_i};
            if (charge_i) begin
                cnt_q   <= '0;
                alive_q <= 1'b1;
            end else if (measure_i) begin
                // first low sample freezes the channel for the rest of the scan
                if (active_o) begin
                    if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
                end else begin
                    alive_q <= 1'b0;
                end
            end
            if (eval_i) last_q <= cnt_q;
            db_q    <= db_d;
            touch_q <= touch_d;
            hit_q   <= (hit_q & ~hit_clr_i) | rise;
        end
    end

`ifdef CAP_BASELINE_EN
    localparam int BW = CNT_W + 4;
    logic [BW-1:0]        base_q, cnt_sh, base_eff;
    logic                 binit_q;
    logic signed [BW+1:0] diff;
    logic [CNT_W:0]       thr_sum;

    assign cnt_sh   = {cnt_q, 4'b0000};
    assign base_eff = binit_q ? base_q : cnt_sh;
    assign thr_sum  = {1'b0, base_eff[BW-1:4]} + {1'b0, threshold_i};
    assign thr_eff  = thr_sum[CNT_W] ? CNT_MAX : thr_sum[CNT_W-1:0];
    assign diff     = $signed({2'b00, cnt_sh}) - $signed({2'b00, base_q});

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            base_q  <= '0;
            binit_q <= 1'b0;
        end else if (eval_i) begin
            if (!binit_q) begin
                base_q  <= cnt_sh;
                binit_q <= 1'b1;
            end else if (!raw && !touch_q) begin
                base_q <= base_q + BW'(diff >>> 4);
            end
        end
    end
`else
    assign thr_eff = threshold_i;
`endif
endmodule

module cap_touch_scanner #(
    parameter int NUM_CH        = 9,
    parameter int CNT_W         = 12,
    parameter int CHARGE_CYCLES = 64,
    parameter int SETTLE_CYCLES = 16,
    parameter int DEBOUNCE      = 3
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [CNT_W-1:0]        threshold,
    input  logic [NUM_CH-1:0]       sensors_in,
    output logic                    sensors_out,
    output logic [NUM_CH-1:0]       touch_state,
    output logic [NUM_CH-1:0]       hit_flags,
    input  logic [NUM_CH-1:0]       hit_clear,
    output logic                    scan_done,
    output logic [NUM_CH*CNT_W-1:0] last_count
);
    localparam int PW0 = (CNT_W > $clog2(CHARGE_CYCLES)) ? CNT_W : $clog2(CHARGE_CYCLES);
    localparam int PW  = (PW0 > $clog2(SETTLE_CYCLES)) ? PW0 : $clog2(SETTLE_CYCLES);
    localparam logic [PW-1:0] TMO = PW'({CNT_W{1'b1}});

    typedef enum logic [2:0] {IDLE, CHARGE, MEASURE, EVAL, SETTLE} state_t;

    state_t            state_q;
    logic [PW-1:0]     phase_q;
    logic              drive_q, done_q;
    logic [NUM_CH-1:0] active;

    assign sensors_out = drive_q;
    assign scan_done   = done_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            phase_q <= '0;
            drive_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (enable) begin
                    state_q <= CHARGE;
                    drive_q <= 1'b1;
                    phase_q <= '0;
                end
                CHARGE: if (phase_q == PW'(CHARGE_CYCLES - 1)) begin
                    state_q <= MEASURE;
                    drive_q <= 1'b0;
                    phase_q <= '0;
                end else begin
                    phase_q <= phase_q + 1'b1;
                end
                MEASURE: if (active == '0 || phase_q == TMO) begin
                    state_q <= EVAL;
                    phase_q <= '0;
                end else begin
                    phase_q <= phase_q + 1'b1;
                end
                EVAL: begin
                    state_q <= SETTLE;
                    done_q  <= 1'b1;
                    phase_q <= '0;
                end
                SETTLE: if (phase_q == PW'(SETTLE_CYCLES - 1)) begin
                    state_q <= IDLE;
                    phase_q <= '0;
                end else begin
                    phase_q <= phase_q + 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    drive_q <= 1'b0;
                    phase_q <= '0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        cap_touch_lane #(.CNT_W(CNT_W), .DEBOUNCE(DEBOUNCE)) u_lane (
            .clock      (clock),
            .reset_n    (reset_n),
            .sens_i     (sensors_in[i]),
            .charge_i   (state_q == CHARGE),
            .measure_i  (state_q == MEASURE),
            .eval_i     (state_q == EVAL),
            .threshold_i(threshold),
            .hit_clr_i  (hit_clear[i]),
            .active_o   (active[i]),
            .count_o    (last_count[i*CNT_W +: CNT_W]),
            .touch_o    (touch_state[i]),
            .hit_o      (hit_flags[i])
        );
    end
endmodule

// File: tb/tb_cap_touch_scanner.sv
// Randomised bench for cap_touch_scanner: pads modelled as hold-after-release delays, scans checked against a per-scan reference model.
module tb_cap_touch_scanner;
    localparam int NUM_CH = 9, CNT_W = 8, CMAX = 255, DEBOUNCE = 3;

    logic                    clock = 1'b0, reset_n = 1'b0, enable = 1'b0;
    logic [CNT_W-1:0]        threshold = 8'd100;
    logic [NUM_CH-1:0]       sensors_in = '0, hit_clear = '0;
    logic [NUM_CH-1:0]       touch_state, hit_flags;
    logic                    sensors_out, scan_done;
    logic [NUM_CH*CNT_W-1:0] last_count;

    int errors = 0, checks = 0;
    int dly[NUM_CH];           // clocks a pad stays high after release; <0 means never charges
    int rel = 0, hi_run = 0, hi_len = 0;
    logic [NUM_CH-1:0] m_touch = '0, m_hit = '0;
    int m_db[NUM_CH];

    always #5 clock = ~clock;

    cap_touch_scanner #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .threshold(threshold),
        .sensors_in(sensors_in), .sensors_out(sensors_out), .touch_state(touch_state),
        .hit_flags(hit_flags), .hit_clear(hit_clear), .scan_done(scan_done),
        .last_count(last_count)
    );

    always @(posedge clock) begin
        #1;
        if (sensors_out) begin
            rel = 0;
            hi_run++;
        end else begin
            rel++;
            if (hi_run > 0) begin hi_len = hi_run; hi_run = 0; end
        end
        for (int i = 0; i < NUM_CH; i++)
            sensors_in[i] = (dly[i] >= 0) && (sensors_out || rel <= dly[i]);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_touch = '0;
        m_hit   = '0;
        for (int i = 0; i < NUM_CH; i++) m_db[i] = 0;
    endtask

    task automatic do_scan(input string tag, input logic [NUM_CH-1:0] clr, output int n);
        logic [NUM_CH-1:0] rise;
        logic raw;
        int c;
        hit_clear = clr;
        n = 0;
        do begin @(posedge clock); #2; n++; end while (!scan_done && n < 3000);
        chk({tag, "_done"}, scan_done, 1'b1);
        rise = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            c   = (dly[i] < 0) ? 0 : ((dly[i] + 2 > CMAX) ? CMAX : dly[i] + 2);
            raw = (c >= int'(threshold));
            if (raw == m_touch[i]) m_db[i] = 0;
            else begin
                m_db[i]++;
                if (m_db[i] == DEBOUNCE) begin
                    m_db[i]    = 0;
                    m_touch[i] = ~m_touch[i];
                    rise[i]    = m_touch[i];
                end
            end
            chk($sformatf("%s_cnt%0d", tag, i), last_count[i*CNT_W +: CNT_W], c);
        end
        m_hit = (m_hit & ~clr) | rise;
        chk({tag, "_touch"}, touch_state, m_touch);
        chk({tag, "_hit"}, hit_flags, m_hit);
    endtask

    initial begin
        int n, k, busy;
        for (int i = 0; i < NUM_CH; i++) dly[i] = -1;
        model_reset();
        repeat (3) @(posedge clock);
        #2;
        chk("rst_drive", sensors_out, 0);
        chk("rst_touch", touch_state, 0);
        chk("rst_hit", hit_flags, 0);
        chk("rst_done", scan_done, 0);
        chk("rst_count", last_count, 0);
        reset_n = 1'b1;
        enable  = 1'b1;

        // idle pads: period and drive width
        for (int s = 0; s < 3; s++) begin
            do_scan($sformatf("zero%0d", s), '0, n);
            if (s > 0) chk($sformatf("period%0d", s), (n >= 83 && n <= 85), 1);
        end
        chk("drive_len", hi_len, 64);

        // channel 2 touch needs three agreeing scans
        for (int i = 0; i < NUM_CH; i++) dly[i] = 20;
        dly[2] = 150;
        do_scan("t2a", '0, n);
        do_scan("t2b", '0, n);
        chk("t2_not_yet", touch_state, 9'b000000000);
        do_scan("t2c", '0, n);
        chk("t2_touch", touch_state, 9'b000000100);
        chk("t2_hit", hit_flags[2], 1);

        // clear of ch2 coinciding with ch5 set; then clear coinciding with own set
        dly[5] = 150;
        do_scan("t5a", '0, n);
        do_scan("t5b", '0, n);
        do_scan("t5c", 9'b000000100, n);
        chk("clr2", hit_flags[2], 0);
        chk("set5", hit_flags[5], 1);
        dly[7] = 150;
        do_scan("t7a", '0, n);
        do_scan("t7b", '0, n);
        do_scan("t7c", 9'b010000000, n);
        chk("set_wins7", hit_flags[7], 1);

        // stuck channel: timeout and saturation
        dly[0] = 100000;
        for (int i = 1; i < NUM_CH; i++) dly[i] = int'($urandom_range(0, 200));
        do_scan("stuck", '0, n);
        chk("stuck_cnt0", last_count[CNT_W-1:0], 255);
        chk("stuck_len", (n >= 82 + 255 && n <= 82 + 257), 1);
        dly[0] = 20;

        // randomised scans
        for (int s = 0; s < 14; s++) begin
            for (int i = 0; i < NUM_CH; i++)
                if ($urandom_range(0, 3) == 0) dly[i] = int'($urandom_range(0, 200)) - 1;
            threshold = 8'(50 * $urandom_range(1, 3));
            do_scan($sformatf("rnd%0d", s), NUM_CH'($urandom), n);
        end

        // threshold 0 touches everything
        threshold = '0;
        for (int s = 0; s < 3; s++) do_scan($sformatf("thr0_%0d", s), '0, n);
        chk("thr0_all", touch_state, 9'h1FF);

        // reset in the middle of MEASURE
        hit_clear = '0;
        for (int i = 0; i < NUM_CH; i++) dly[i] = 200;
        k = 0;
        while (!sensors_out && k < 500) begin @(posedge clock); #2; k++; end
        while (sensors_out && k < 500) begin @(posedge clock); #2; k++; end
        chk("reach_measure", k < 500, 1);
        repeat (20) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_drive", sensors_out, 0);
        chk("async_touch", touch_state, 0);
        chk("async_hit", hit_flags, 0);
        chk("async_count", last_count, 0);
        #7;
        reset_n = 1'b1;
        model_reset();
        threshold = 8'd100;
        for (int i = 0; i < NUM_CH; i++) dly[i] = (i % 2 == 0) ? 130 : 40;
        for (int s = 0; s < 3; s++) do_scan($sformatf("post%0d", s), '0, n);

        // enable dropped mid-scan: scan completes, then halt
        repeat (30) @(posedge clock);
        #2;
        enable = 1'b0;
        do_scan("endrop", '0, n);
        busy = 0;
        repeat (400) begin
            @(posedge clock); #2;
            if (scan_done || sensors_out) busy++;
        end
        chk("halted", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
